// File: rtl/peasant_pkg.sv
// Shared types and default sizing for the peasant multiplier/accumulator chain.
package peasant_pkg;

  typedef enum logic [1:0] {IDLE, ACC, OUT} acc_state_t;

  localparam int N_DEF = 16;
  localparam int G_DEF = 4;
  localparam int L_DEF = 8;

  // Accumulator width: full product plus guard bits.
  function automatic int acc_width(input int n, input int g);
    return 2 * n + g;
  endfunction

endpackage

// File: rtl/edge_det_r.sv
// Rising-edge detector on a level flag, with a configurable reset value for the history bit.
// Latency: rise_o is combinational from d_i against the registered previous level.
// Backpressure: none; an edge is reported for exactly one cycle.
module edge_det_r #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) d_q <= RST_VAL;
    else        d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/peasant_mac_acc.sv
// Accumulates len multiplier products (one per done-flag rising edge) and presents the sum.
// Latency: valid_o rises one cycle after the final flag edge (or after start with len 0).
// Backpressure: result held in OUT until ready_i; flag edges arriving meanwhile are dropped.
module peasant_mac_acc
  import peasant_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int G = G_DEF,
  parameter int L = L_DEF,
  localparam int W = acc_width(N, G)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [L-1:0]   len_i,
  input  logic           fl_i,
  input  logic [2*N-1:0] y_i,
  output logic [W-1:0]   sum_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic           ovf_o,
  output logic           busy_o,
  output logic [L-1:0]   cnt_o
);

  acc_state_t  state;
  logic [L-1:0] len_q;
  logic        prod_ev;
  logic        load;
  logic [W:0]  add_sum;
  logic [L-1:0] cnt_inc;

  // History resets high so a flag already asserted out of reset is not counted.
  edge_det_r #(.RST_VAL(1'b1)) u_fl_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (fl_i),
    .rise_o (prod_ev)
  );

  assign load    = start_i & ((state == IDLE) | ((state == OUT) & ready_i));
  assign add_sum = {1'b0, sum_o} + {{(W + 1 - 2 * N){1'b0}}, y_i};
  assign cnt_inc = cnt_o + L'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      sum_o <= '0;
      ovf_o <= 1'b0;
      cnt_o <= '0;
      len_q <= '0;
    end else if (load) begin
      len_q <= len_i;
      sum_o <= '0;
      cnt_o <= '0;
      ovf_o <= 1'b0;
      state <= (len_i == '0) ? OUT : ACC;
    end else begin
      case (state)
        ACC: begin
          if (prod_ev) begin
            sum_o <= add_sum[W-1:0];
            ovf_o <= ovf_o | add_sum[W];
            cnt_o <= cnt_inc;
            if (cnt_inc == len_q) state <= OUT;
          end
        end
        OUT: begin
          if (ready_i) state <= IDLE;
        end
        IDLE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state == ACC);
  assign valid_o = (state == OUT);

endmodule

// File: tb/tb_peasant_mac_acc.sv
// Directed plus randomized frames checked against a sum-of-products reference model.
module tb_peasant_mac_acc;

  localparam int N = 16;
  localparam int G = 4;
  localparam int L = 8;
  localparam int W = 2 * N + G;
  localparam logic [63:0] WMASK = (64'd1 << W) - 64'd1;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic           start_i = 1'b0;
  logic [L-1:0]   len_i = '0;
  logic           fl_i = 1'b1;
  logic [2*N-1:0] y_i = '0;
  logic [W-1:0]   sum_o;
  logic           valid_o;
  logic           ready_i = 1'b0;
  logic           ovf_o;
  logic           busy_o;
  logic [L-1:0]   cnt_o;

  int total = 0;
  int bad = 0;

  // Reference model state: arithmetic total of accepted products.
  longint unsigned ref_total;
  int              ref_cnt;

  peasant_mac_acc #(.N(N), .G(G), .L(L)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .len_i   (len_i),
    .fl_i    (fl_i),
    .y_i     (y_i),
    .sum_o   (sum_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o),
    .cnt_o   (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int len);
    start_i = 1'b1;
    len_i   = L'(len);
    @(negedge clk_i);
    start_i = 1'b0;
    ref_total = 0;
    ref_cnt   = 0;
  endtask

  task automatic pulse(input logic [2*N-1:0] y);
    fl_i = 1'b1;
    y_i  = y;
    @(negedge clk_i);
    fl_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic model_add(input logic [2*N-1:0] y);
    ref_total += longint'(y);
    ref_cnt++;
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".valid"}, 64'(valid_o), 64'd1);
    chk({tag, ".sum"},   64'(sum_o),   ref_total & WMASK);
    chk({tag, ".cnt"},   64'(cnt_o),   64'(ref_cnt));
    chk({tag, ".ovf"},   64'(ovf_o),   64'(ref_total > WMASK));
  endtask

  task automatic drain();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  initial begin
    logic [2*N-1:0] y;
    int len;
    #1;
    chk("rst.valid", 64'(valid_o), 64'd0);
    chk("rst.busy",  64'(busy_o),  64'd0);
    chk("rst.sum",   64'(sum_o),   64'd0);
    chk("rst.cnt",   64'(cnt_o),   64'd0);
    chk("rst.ovf",   64'(ovf_o),   64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Flag high out of reset must not count as a product.
    start_frame(1);
    y_i = 32'd77;
    @(negedge clk_i);
    chk("boot.nocount", 64'(cnt_o), 64'd0);
    fl_i = 1'b0;
    @(negedge clk_i);
    pulse(32'd3); model_add(32'd3);
    chk_result("boot");
    drain();

    // Basic frame, with latency check on the final edge.
    start_frame(3);
    chk("basic.busy", 64'(busy_o), 64'd1);
    pulse(32'd6);  model_add(32'd6);
    pulse(32'd15); model_add(32'd15);
    chk("basic.notyet", 64'(valid_o), 64'd0);
    fl_i = 1'b1; y_i = 32'd100;
    @(negedge clk_i);
    model_add(32'd100);
    chk("basic.lat", 64'(valid_o), 64'd1);
    fl_i = 1'b0;
    chk_result("basic");
    chk("basic.sum121", 64'(sum_o), 64'd121);
    drain();
    chk("basic.idle", 64'(valid_o), 64'd0);
    chk("basic.hold", 64'(sum_o), 64'd121);

    // Held flag counts once.
    start_frame(2);
    fl_i = 1'b1; y_i = 32'd7;
    repeat (5) @(negedge clk_i);
    model_add(32'd7);
    chk("held.cnt", 64'(cnt_o), 64'd1);
    fl_i = 1'b0;
    @(negedge clk_i);
    pulse(32'd9); model_add(32'd9);
    chk_result("held");
    drain();

    // Zero length: result the next cycle, no edges consumed.
    start_frame(0);
    chk_result("zero");
    pulse(32'd55);
    chk_result("zero.drop");
    drain();

    // Overflow wrap with 17 full-scale products, then exactly 16.
    start_frame(17);
    for (int i = 0; i < 17; i++) begin pulse(32'hFFFF_FFFF); model_add(32'hFFFF_FFFF); end
    chk_result("ovf17");
    chk("ovf17.abs", 64'(sum_o), 64'h0_FFFF_FFEF);
    drain();
    start_frame(16);
    for (int i = 0; i < 16; i++) begin pulse(32'hFFFF_FFFF); model_add(32'hFFFF_FFFF); end
    chk_result("ovf16");
    chk("ovf16.abs", 64'(sum_o), 64'hF_FFFF_FFF0);
    drain();

    // Backpressure with a dropped edge, then back-to-back restart.
    start_frame(1);
    pulse(32'd42); model_add(32'd42);
    pulse(32'd1000);
    @(negedge clk_i);
    chk_result("bp");
    ready_i = 1'b1; start_i = 1'b1; len_i = 8'd1;
    @(negedge clk_i);
    ready_i = 1'b0; start_i = 1'b0;
    ref_total = 0; ref_cnt = 0;
    chk("b2b.busy", 64'(busy_o), 64'd1);
    chk("b2b.clr",  64'(sum_o),  64'd0);
    pulse(32'd5); model_add(32'd5);
    chk_result("b2b");
    drain();

    // Start is ignored mid-frame.
    start_frame(2);
    pulse(32'd11); model_add(32'd11);
    start_i = 1'b1; len_i = 8'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("accstart.cnt", 64'(cnt_o), 64'd1);
    pulse(32'd4); model_add(32'd4);
    chk_result("accstart");
    drain();

    // Reset mid-frame with flag high across release.
    start_frame(4);
    pulse(32'd20);
    pulse(32'd30);
    fl_i = 1'b1; y_i = 32'd99;
    rst_i = 1'b0;
    #1;
    chk("mrst.sum",  64'(sum_o),  64'd0);
    chk("mrst.cnt",  64'(cnt_o),  64'd0);
    chk("mrst.busy", 64'(busy_o), 64'd0);
    chk("mrst.valid", 64'(valid_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    start_frame(1);
    @(negedge clk_i);
    chk("mrst.noev", 64'(cnt_o), 64'd0);
    fl_i = 1'b0;
    @(negedge clk_i);
    pulse(32'd3); model_add(32'd3);
    chk_result("mrst");
    drain();

    // Randomized frames with gaps, full-scale bias and random backpressure.
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 20);
      start_frame(len);
      for (int p = 0; p < len; p++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        y = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom);
        pulse(y); model_add(y);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      chk_result($sformatf("rnd%0d", f));
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peasant_mac_acc.md
Name: peasant_mac_acc

Overview:
Downstream accumulation stage for peasant_multi_nxn.
- Watches the multiplier's done flag and its product output.
- Adds each completed product into a wide accumulator. After a programmed number of products, presents the dot-product sum on a valid/ready output.
- Sits between the multiplier and any result consumer (bus/UART/display logic).

Parameters:
N, 16, operand width of the upstream multiplier; product width is 2N
G, 4, guard bits; accumulator width W = 2N+G
L, 8, width of the product-count (length) field

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  begin new accumulation frame (honoured in IDLE, or in OUT together with handshake)
len_i  input  L  number of products in frame, sampled with accepted start_i
fl_i  input  1  multiplier done flag (level, from fl_o)
y_i  input  2N  multiplier product (from y_o), valid when fl_i high
sum_o  output  W  accumulated sum
valid_o  output  1  sum_o valid
ready_i  input  1  consumer accepts sum_o
ovf_o  output  1  sticky: accumulator carry-out occurred in current frame
busy_o  output  1  high in ACC state
cnt_o  output  L  products accumulated so far in current frame

Behaviour:
- Reset (rst_i=0, async): state IDLE, sum_o=0, valid_o=0, ovf_o=0, busy_o=0, cnt_o=0, len register=0, fl_q=1.
- fl_q resets to 1 so a flag already high out of reset is not counted.
- Edge detect: fl_q <= fl_i every cycle in every state. A product event is fl_i & ~fl_q. A held-high flag counts once.
- States: IDLE, ACC, OUT.
- IDLE:
  - On start_i: latch len_i, clear sum/cnt/ovf.
  - If len_i==0, next state is OUT, so sum_o=0 with valid_o the following cycle.
  - Otherwise next state is ACC.
  - Product events in IDLE are ignored.
- ACC:
  - On product event: {carry, sum} = sum + zero-extended y_i; cnt++. Carry sets ovf_o (sticky); sum wraps modulo 2^W.
  - When the incremented cnt equals len, next state is OUT. valid_o rises the cycle after the last add, so latency is 1 cycle from the final flag edge.
  - start_i is ignored in ACC.
- OUT:
  - valid_o=1; sum_o, ovf_o and cnt_o are held stable while ready_i=0.
  - Product events are ignored (dropped).
  - On valid_o & ready_i with start_i=0: next state IDLE, valid_o=0. sum_o retains its value until the next start.
  - On valid_o & ready_i & start_i: back-to-back frame. Latch len_i, clear sum/cnt/ovf, go to ACC (or stay in OUT with sum 0 if len_i==0).
- busy_o = (state==ACC). valid_o = (state==OUT). Both are registered/state-decoded, with no combinational path from inputs.
- Reset mid-frame: partial sum discarded, all outputs return to reset values immediately.
- Width rule: y_i is zero-extended to W. Up to 2^G full-scale products are guaranteed not to overflow.

Decomposition:
- Shared package peasant_pkg:
  - state enum acc_state_t {IDLE, ACC, OUT}
  - default N/G/L constants
  - localparam W function
- One natural sub-module: edge_det_r, a 1-bit rising-edge detector with configurable reset value. It is reusable for other flag-driven stages.
- The accumulator register uses the existing dff_n_data style with reset value 0.

Test Plan:
(All with N=16, G=4, L=8.)
1. Basic frame: start_i, len=3; fl_i edges with y_i=6, 15, 100 -> valid_o=1 one cycle after third edge, sum_o=121, cnt_o=3, ovf_o=0.
2. Held flag: len=2; fl_i held high 5 cycles with y_i=7, then low, then edge with y_i=9 -> sum_o=16 (flag counted once, not 5).
3. Zero length: start_i with len=0 -> valid_o=1 next cycle, sum_o=0, cnt_o=0; no fl_i edges consumed.
4. Overflow wrap: len=17, each y_i=0xFFFF_FFFF -> sum_o=0x0_FFFF_FFEF, ovf_o=1. Repeat with len=16 -> sum_o=0xF_FFFF_FFF0, ovf_o=0.
5. Backpressure and back-to-back:
   - len=1, y_i=42, ready_i low 4 cycles with an extra fl_i edge -> sum_o stays 42, edge ignored.
   - ready_i=1 with start_i=1, len=1, then edge y_i=5 -> second frame sum_o=5.
6. Reset mid-frame: len=4, two edges accumulated, then rst_i=0 for 1 cycle -> all outputs 0, state IDLE; fl_i still high after release produces no event.
